multicycle_controller: RTL and testbench

Parametrised FSM control unit for the multi-cycle generation of the RV32I processor, replacing the single-cycle decoder. It sequences each instruction over 3–5 cycles through one shared ALU and memory port. It adds a memory wait-state handshake, extended branches (bne/blt/bge), lui/auipc support, and an illegal-instruction trap.

---
 rtl/multicycle_controller_if.sv | 38 +++
 rtl/multicycle_controller.sv | 190 +++++++++++++++++++
 tb/tb_multicycle_controller.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_if.sv
// Control bus between the multi-cycle RV32I controller and its datapath.
// Instruction fields, ALU flags and the memory handshake go from the datapath
// to the controller. Strobes, mux selects, ALU op, immediate format, trap flag
// and the debug state go back the other way.
//   master : controller side (drives the control outputs)
//   slave  : datapath side (drives instruction fields, flags and MemReady)
interface multicycle_controller_if;
  logic [6:0] OPcode;
  logic [2:0] Funct3;
  logic       Funct7b5;
  logic       Zero;
  logic       Lt;
  logic       MemReady;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] ResultSrc;
  logic [2:0] ALUControl;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ImmSrc;
  logic       RegWrite;
  logic       Illegal;
  logic [3:0] State;

  modport master (
    input  OPcode, Funct3, Funct7b5, Zero, Lt, MemReady,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUControl,
           ALUSrcA, ALUSrcB, ImmSrc, RegWrite, Illegal, State
  );

  modport slave (
    output OPcode, Funct3, Funct7b5, Zero, Lt, MemReady,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUControl,
           ALUSrcA, ALUSrcB, ImmSrc, RegWrite, Illegal, State
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM. It sequences each instruction over 3-5 cycles
// (plus memory wait states) through one shared ALU and one memory port.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-low; forces FETCH and masks all enables
//   bus   : multicycle_controller_if.master (instruction fields, flags,
//           MemReady in; strobes, mux selects, ALU op, ImmSrc, Illegal,
//           State out)
// Parameters:
//   MEM_WAIT     : 1 = memory states stall on MemReady, 0 = MemReady ignored
//   BRANCH_EXT   : 1 = beq/bne/blt/bge, 0 = beq only
//   ILLEGAL_TRAP : 1 = bad encodings park in TRAP, 0 = they return to FETCH
module multicycle_controller #(
  parameter bit MEM_WAIT     = 1'b1,
  parameter bit BRANCH_EXT   = 1'b1,
  parameter bit ILLEGAL_TRAP = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  multicycle_controller_if.master bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    LUI      = 4'd11,
    AUIPC    = 4'd12,
    TRAP     = 4'd15
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101
  } alu_t;

  state_t state;
  state_t decode_next;
  state_t illegal_next;
  alu_t   alu_funct;
  logic   ready;
  logic   funct_ok;
  logic   branch_ok;
  logic   taken;

  assign ready     = MEM_WAIT ? bus.MemReady : 1'b1;
  assign funct_ok  = bus.Funct3 inside {3'b000, 3'b010, 3'b100, 3'b110, 3'b111};
  assign branch_ok = BRANCH_EXT ? (bus.Funct3 inside {3'b000, 3'b001, 3'b100, 3'b101})
                                : (bus.Funct3 == 3'b000);
  assign bus.State = state;

  always_comb begin
    if (ILLEGAL_TRAP) illegal_next = TRAP;
    else              illegal_next = FETCH;
  end

  // R-type sub is the only funct3=000 case that subtracts; I-type never does.
  always_comb begin
    alu_funct = ALU_ADD;
    case (bus.Funct3)
      3'b000:  if (bus.OPcode[5] && bus.Funct7b5) alu_funct = ALU_SUB;
      3'b010:  alu_funct = ALU_SLT;
      3'b100:  alu_funct = ALU_XOR;
      3'b110:  alu_funct = ALU_OR;
      3'b111:  alu_funct = ALU_AND;
      default: alu_funct = ALU_ADD;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (bus.Funct3)
      3'b000:  taken = bus.Zero;
      3'b001:  taken = !bus.Zero;
      3'b100:  taken = bus.Lt;
      3'b101:  taken = !bus.Lt;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    decode_next = illegal_next;
    case (bus.OPcode)
      7'b0000011, 7'b0100011: decode_next = MEMADR;
      7'b0110011: if (funct_ok)  decode_next = EXECUTER;
      7'b0010011: if (funct_ok)  decode_next = EXECUTEI;
      7'b1100011: if (branch_ok) decode_next = BRANCH;
      7'b1101111: decode_next = JAL;
      7'b0110111: decode_next = LUI;
      7'b0010111: decode_next = AUIPC;
      default:    decode_next = illegal_next;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
    end else begin
      case (state)
        FETCH:    if (ready) state <= DECODE;
        DECODE:   state <= decode_next;
        MEMADR:   if (bus.OPcode[5]) state <= MEMWRITE;
                  else               state <= MEMREAD;
        MEMREAD:  if (ready) state <= MEMWB;
        MEMWB:    state <= FETCH;
        MEMWRITE: if (ready) state <= FETCH;
        EXECUTER, EXECUTEI, JAL, LUI, AUIPC: state <= ALUWB;
        ALUWB, BRANCH: state <= FETCH;
        TRAP:     state <= TRAP;
        default:  state <= FETCH;
      endcase
    end
  end

  always_comb begin
    bus.ImmSrc = 3'b000;
    case (bus.OPcode)
      7'b0100011:             bus.ImmSrc = 3'b001;
      7'b1100011:             bus.ImmSrc = 3'b010;
      7'b1101111:             bus.ImmSrc = 3'b011;
      7'b0110111, 7'b0010111: bus.ImmSrc = 3'b100;
      default:                bus.ImmSrc = 3'b000;
    endcase
  end

  // Enables are masked by reset combinationally so an abort mid-access
  // (e.g. a store waiting on MemReady) drops the strobe without a clock edge.
  always_comb begin
    bus.PCWrite    = 1'b0;
    bus.AdrSrc     = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.ResultSrc  = 2'b00;
    bus.ALUControl = ALU_ADD;
    bus.ALUSrcA    = 2'b00;
    bus.ALUSrcB    = 2'b00;
    bus.RegWrite   = 1'b0;
    bus.Illegal    = 1'b0;
    case (state)
      FETCH: begin
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
        bus.IRWrite   = ready;
        bus.PCWrite   = ready;
      end
      DECODE:   begin bus.ALUSrcA = 2'b01; bus.ALUSrcB = 2'b01; end
      MEMADR:   begin bus.ALUSrcA = 2'b10; bus.ALUSrcB = 2'b01; end
      MEMREAD:  bus.AdrSrc = 1'b1;
      MEMWB:    begin bus.ResultSrc = 2'b01; bus.RegWrite = 1'b1; end
      MEMWRITE: begin bus.AdrSrc = 1'b1; bus.MemWrite = 1'b1; end
      EXECUTER: begin bus.ALUSrcA = 2'b10; bus.ALUControl = alu_funct; end
      EXECUTEI: begin
        bus.ALUSrcA    = 2'b10;
        bus.ALUSrcB    = 2'b01;
        bus.ALUControl = alu_funct;
      end
      ALUWB:    bus.RegWrite = 1'b1;
      BRANCH:   begin
        bus.ALUSrcA    = 2'b10;
        bus.ALUControl = ALU_SUB;
        bus.PCWrite    = taken;
      end
      JAL:      begin bus.ALUSrcA = 2'b01; bus.ALUSrcB = 2'b10; bus.PCWrite = 1'b1; end
      LUI:      begin bus.ALUSrcA = 2'b11; bus.ALUSrcB = 2'b01; end
      AUIPC:    begin bus.ALUSrcA = 2'b01; bus.ALUSrcB = 2'b01; end
      TRAP:     bus.Illegal = 1'b1;
      default:  ;
    endcase
    if (!reset) begin
      bus.PCWrite  = 1'b0;
      bus.IRWrite  = 1'b0;
      bus.MemWrite = 1'b0;
      bus.RegWrite = 1'b0;
      bus.Illegal  = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomised scoreboard bench for multicycle_controller. Three instances cover
// the default build, a no-wait/beq-only build and a no-trap build. For every
// instruction the bench derives the expected per-cycle control pattern from
// the instruction class, the wait states it chose and the parameter set, and
// queues it; a monitor on the falling edge compares one entry per cycle.
module tb_multicycle_controller;

  localparam logic [3:0] S_FETCH = 4'd0,  S_DECODE = 4'd1, S_MEMADR = 4'd2,
                         S_MEMRD = 4'd3,  S_MEMWB  = 4'd4, S_MEMWR  = 4'd5,
                         S_EXR   = 4'd6,  S_EXI    = 4'd7, S_ALUWB  = 4'd8,
                         S_BR    = 4'd9,  S_JAL    = 4'd10, S_LUI   = 4'd11,
                         S_AUIPC = 4'd12, S_TRAP   = 4'd15;
  // {PCWrite, IRWrite, MemWrite, RegWrite, Illegal}
  localparam logic [4:0] E_NONE = 5'b00000, E_PC = 5'b10000, E_IR = 5'b01000,
                         E_MW = 5'b00100, E_RW = 5'b00010, E_IL = 5'b00001;
  // mux vector {AdrSrc, ResultSrc[1:0], ALUSrcA[1:0], ALUSrcB[1:0]}
  localparam logic [6:0] K_ALL = 7'h7f, K_AB = 7'b0001111, K_AR = 7'b1110000,
                         K_R = 7'b0110000, K_RAB = 7'b0111111;
  localparam int C_LW = 0, C_SW = 1, C_R = 2, C_I = 3, C_BR = 4, C_JAL = 5,
                 C_LUI = 6, C_AUIPC = 7, C_BAD = 8;

  typedef struct {
    logic       ready;
    logic       rstn;
    logic [3:0] st;
    logic [4:0] en;
    logic [6:0] mux;
    logic [6:0] care;
    logic [2:0] alu;
    logic       alu_care;
    logic [2:0] imm;
    logic       imm_care;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst0 = 1'b0, rst1 = 1'b0, rst2 = 1'b0;
  logic [6:0] opc = '0;
  logic [2:0] f3 = '0;
  logic       f7 = 1'b0, zero = 1'b0, lt = 1'b0, mem_ready = 1'b0;
  logic [1:0] sel = 2'd0;
  logic       p_wait = 1'b1, p_bext = 1'b1, p_trap = 1'b1;

  logic [6:0] cur_opc = '0;
  logic [2:0] cur_f3 = '0;
  logic       cur_f7 = 1'b0, cur_z = 1'b0, cur_lt = 1'b0;
  logic [2:0] cur_imm = '0;
  logic       cur_imm_care = 1'b0;

  rec_t plan[$];
  rec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  multicycle_controller_if if0 ();
  multicycle_controller_if if1 ();
  multicycle_controller_if if2 ();

  assign if0.OPcode = opc;  assign if1.OPcode = opc;  assign if2.OPcode = opc;
  assign if0.Funct3 = f3;   assign if1.Funct3 = f3;   assign if2.Funct3 = f3;
  assign if0.Funct7b5 = f7; assign if1.Funct7b5 = f7; assign if2.Funct7b5 = f7;
  assign if0.Zero = zero;   assign if1.Zero = zero;   assign if2.Zero = zero;
  assign if0.Lt = lt;       assign if1.Lt = lt;       assign if2.Lt = lt;
  assign if0.MemReady = mem_ready;
  assign if1.MemReady = mem_ready;
  assign if2.MemReady = mem_ready;

  multicycle_controller u_dut (.clk(clk), .reset(rst0), .bus(if0));
  multicycle_controller #(.MEM_WAIT(1'b0), .BRANCH_EXT(1'b0), .ILLEGAL_TRAP(1'b1))
    u_alt (.clk(clk), .reset(rst1), .bus(if1));
  multicycle_controller #(.MEM_WAIT(1'b1), .BRANCH_EXT(1'b1), .ILLEGAL_TRAP(1'b0))
    u_notrap (.clk(clk), .reset(rst2), .bus(if2));

  logic [3:0] o_st;
  logic [4:0] o_en;
  logic [6:0] o_mux;
  logic [2:0] o_alu, o_imm;

  assign o_st = (sel == 2'd0) ? if0.State : (sel == 2'd1) ? if1.State : if2.State;
  assign o_en = (sel == 2'd0) ? {if0.PCWrite, if0.IRWrite, if0.MemWrite, if0.RegWrite, if0.Illegal}
              : (sel == 2'd1) ? {if1.PCWrite, if1.IRWrite, if1.MemWrite, if1.RegWrite, if1.Illegal}
              :                 {if2.PCWrite, if2.IRWrite, if2.MemWrite, if2.RegWrite, if2.Illegal};
  assign o_mux = (sel == 2'd0) ? {if0.AdrSrc, if0.ResultSrc, if0.ALUSrcA, if0.ALUSrcB}
               : (sel == 2'd1) ? {if1.AdrSrc, if1.ResultSrc, if1.ALUSrcA, if1.ALUSrcB}
               :                 {if2.AdrSrc, if2.ResultSrc, if2.ALUSrcA, if2.ALUSrcB};
  assign o_alu = (sel == 2'd0) ? if0.ALUControl : (sel == 2'd1) ? if1.ALUControl : if2.ALUControl;
  assign o_imm = (sel == 2'd0) ? if0.ImmSrc : (sel == 2'd1) ? if1.ImmSrc : if2.ImmSrc;

  // Monitor: one expected entry per cycle while the scoreboard holds work.
  initial begin
    rec_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if (o_st !== e.st || o_en !== e.en ||
            (o_mux & e.care) !== (e.mux & e.care) ||
            (e.alu_care && o_alu !== e.alu) ||
            (e.imm_care && o_imm !== e.imm)) begin
          errors++;
          $display("FAIL cycle_check#%0d dut%0d (actual/required) state=%0d/%0d en=%b/%b mux=%b/%b care=%b alu=%0d/%0d imm=%0d/%0d",
                   checks, sel, o_st, e.st, o_en, e.en, o_mux, e.mux, e.care,
                   o_alu, e.alu, o_imm, e.imm);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached, queue=%0d required=0", exp_q.size());
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] opcode_of(input int cls);
    case (cls)
      C_LW:    return 7'b0000011;
      C_SW:    return 7'b0100011;
      C_R:     return 7'b0110011;
      C_I:     return 7'b0010011;
      C_BR:    return 7'b1100011;
      C_JAL:   return 7'b1101111;
      C_LUI:   return 7'b0110111;
      default: return 7'b0010111;
    endcase
  endfunction

  function automatic logic [2:0] imm_of(input int cls);
    case (cls)
      C_SW:           return 3'd1;
      C_BR:           return 3'd2;
      C_JAL:          return 3'd3;
      C_LUI, C_AUIPC: return 3'd4;
      default:        return 3'd0;
    endcase
  endfunction

  function automatic logic [2:0] funct_alu(input logic [2:0] f, input logic is_sub);
    case (f)
      3'd0:    return is_sub ? 3'd1 : 3'd0;
      3'd2:    return 3'd5;
      3'd4:    return 3'd4;
      3'd6:    return 3'd3;
      default: return 3'd2;
    endcase
  endfunction

  function automatic logic [6:0] rand_bad();
    logic [6:0] o;
    do o = 7'($urandom_range(0, 127));
    while (o inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                     7'b1100011, 7'b1101111, 7'b0110111, 7'b0010111});
    return o;
  endfunction

  function automatic rec_t mk(input logic [3:0] st, input logic [4:0] en,
                              input logic [6:0] mux, input logic [6:0] care,
                              input logic [2:0] alu, input logic alu_care);
    rec_t r;
    r.ready = p_wait ? 1'($urandom_range(0, 1)) : 1'b0;
    r.rstn = 1'b1;
    r.st = st; r.en = en; r.mux = mux; r.care = care;
    r.alu = alu; r.alu_care = alu_care;
    r.imm = cur_imm; r.imm_care = cur_imm_care;
    return r;
  endfunction

  function automatic rec_t reset_rec();
    rec_t r;
    r = mk(S_FETCH, E_NONE, 7'h0, 7'h0, 3'd0, 1'b0);
    r.rstn = 1'b0;
    r.ready = 1'b1;
    return r;
  endfunction

  // Access that waits on MemReady: 'waits' stalled cycles then the completing one.
  task automatic push_mem(input logic [3:0] st, input logic [4:0] en_wait,
                          input logic [4:0] en_done, input logic [6:0] mux,
                          input logic [6:0] care, input logic alu_care, input int waits);
    rec_t r;
    if (p_wait)
      for (int i = 0; i < waits; i++) begin
        r = mk(st, en_wait, mux, care, 3'd0, alu_care);
        r.ready = 1'b0;
        plan.push_back(r);
      end
    r = mk(st, en_done, mux, care, 3'd0, alu_care);
    r.ready = p_wait;
    plan.push_back(r);
  endtask

  task automatic issue();
    foreach (plan[i]) exp_q.push_back(plan[i]);
    foreach (plan[i]) begin
      @(posedge clk);
      #1;
      if (i == 0) begin
        opc = cur_opc; f3 = cur_f3; f7 = cur_f7; zero = cur_z; lt = cur_lt;
      end
      mem_ready = plan[i].ready;
      case (sel)
        2'd0:    rst0 = plan[i].rstn;
        2'd1:    rst1 = plan[i].rstn;
        default: rst2 = plan[i].rstn;
      endcase
    end
  endtask

  task automatic do_reset();
    plan.delete();
    cur_imm_care = 1'b0;
    plan.push_back(reset_rec());
    issue();
  endtask

  task automatic run(input int cls, input logic [2:0] fi, input logic f7i,
                     input logic zi, input logic lti, input int wf, input int wm,
                     input int abort_at, input int trap_len, input logic [6:0] bad_opc);
    logic ok, tk;
    plan.delete();
    cur_opc = (cls == C_BAD) ? bad_opc : opcode_of(cls);
    cur_f3 = fi; cur_f7 = f7i; cur_z = zi; cur_lt = lti;
    cur_imm = imm_of(cls);
    cur_imm_care = !(cls == C_BAD || cls == C_R);
    tk = (fi == 3'd0) ? zi : (fi == 3'd1) ? !zi : (fi == 3'd4) ? lti : !lti;

    push_mem(S_FETCH, E_NONE, E_PC | E_IR, 7'b0_10_00_10, K_ALL, 1'b1, wf);
    plan.push_back(mk(S_DECODE, E_NONE, 7'b0_00_01_01, K_AB, 3'd0, 1'b1));
    ok = 1'b1;
    case (cls)
      C_LW: begin
        plan.push_back(mk(S_MEMADR, E_NONE, 7'b0_00_10_01, K_AB, 3'd0, 1'b1));
        push_mem(S_MEMRD, E_NONE, E_NONE, 7'b1_00_00_00, K_AR, 1'b0, wm);
        plan.push_back(mk(S_MEMWB, E_RW, 7'b0_01_00_00, K_R, 3'd0, 1'b0));
      end
      C_SW: begin
        plan.push_back(mk(S_MEMADR, E_NONE, 7'b0_00_10_01, K_AB, 3'd0, 1'b1));
        push_mem(S_MEMWR, E_MW, E_MW, 7'b1_00_00_00, K_AR, 1'b0, wm);
      end
      C_R, C_I: begin
        ok = fi inside {3'd0, 3'd2, 3'd4, 3'd6, 3'd7};
        if (ok) begin
          if (cls == C_R)
            plan.push_back(mk(S_EXR, E_NONE, 7'b0_00_10_00, K_AB, funct_alu(fi, f7i), 1'b1));
          else
            plan.push_back(mk(S_EXI, E_NONE, 7'b0_00_10_01, K_AB, funct_alu(fi, 1'b0), 1'b1));
          plan.push_back(mk(S_ALUWB, E_RW, 7'b0_00_00_00, K_R, 3'd0, 1'b0));
        end
      end
      C_BR: begin
        ok = p_bext ? (fi inside {3'd0, 3'd1, 3'd4, 3'd5}) : (fi == 3'd0);
        if (ok)
          plan.push_back(mk(S_BR, tk ? E_PC : E_NONE, 7'b0_00_10_00, K_RAB, 3'd1, 1'b1));
      end
      C_JAL, C_LUI, C_AUIPC: begin
        if (cls == C_JAL)
          plan.push_back(mk(S_JAL, E_PC, 7'b0_00_01_10, K_RAB, 3'd0, 1'b1));
        else if (cls == C_LUI)
          plan.push_back(mk(S_LUI, E_NONE, 7'b0_00_11_01, K_AB, 3'd0, 1'b1));
        else
          plan.push_back(mk(S_AUIPC, E_NONE, 7'b0_00_01_01, K_AB, 3'd0, 1'b1));
        plan.push_back(mk(S_ALUWB, E_RW, 7'b0_00_00_00, K_R, 3'd0, 1'b0));
      end
      default: ok = 1'b0;
    endcase
    if (!ok && p_trap) begin
      for (int i = 0; i < trap_len; i++)
        plan.push_back(mk(S_TRAP, E_IL, 7'h0, 7'h0, 3'd0, 1'b0));
      plan.push_back(reset_rec());
    end
    if (abort_at >= 1 && abort_at < plan.size()) begin
      while (plan.size() > abort_at) void'(plan.pop_back());
      plan.push_back(reset_rec());
    end
    issue();
  endtask

  task automatic rand_instr();
    int cls;
    logic [2:0] fi;
    cls = $urandom_range(0, 8);
    fi = 3'($urandom_range(0, 7));
    if ((cls == C_R || cls == C_I) && $urandom_range(0, 4) != 0)
      case ($urandom_range(0, 4))
        0: fi = 3'd0; 1: fi = 3'd2; 2: fi = 3'd4; 3: fi = 3'd6; default: fi = 3'd7;
      endcase
    if (cls == C_BR && $urandom_range(0, 4) != 0)
      case ($urandom_range(0, 3))
        0: fi = 3'd0; 1: fi = 3'd1; 2: fi = 3'd4; default: fi = 3'd5;
      endcase
    run(cls, fi, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
        1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 2),
        ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 6)) : -1,
        $urandom_range(1, 4), rand_bad());
  endtask

  task automatic begin_phase(input logic [1:0] s, input logic w, input logic b, input logic t);
    sel = s; p_wait = w; p_bext = b; p_trap = t;
    do_reset();
  endtask

  task automatic end_phase();
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain dut%0d queue=%0d required=0", sel, exp_q.size());
      exp_q.delete();
    end
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
  endtask

  initial begin
    // Default build: waits, extended branches, trapping.
    begin_phase(2'd0, 1'b1, 1'b1, 1'b1);
    run(C_R, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0, -1, 0, 7'h0);   // add
    run(C_R, 3'd0, 1'b1, 1'b0, 1'b0, 0, 0, -1, 0, 7'h0);   // sub
    run(C_LW, 3'd2, 1'b0, 1'b0, 1'b0, 0, 2, -1, 0, 7'h0);  // lw, 2 data waits
    run(C_BR, 3'd1, 1'b0, 1'b1, 1'b0, 0, 0, -1, 0, 7'h0);  // bne not taken
    run(C_BR, 3'd1, 1'b0, 1'b0, 1'b0, 0, 0, -1, 0, 7'h0);  // bne taken
    run(C_BR, 3'd4, 1'b0, 1'b0, 1'b1, 1, 0, -1, 0, 7'h0);  // blt taken
    run(C_BR, 3'd5, 1'b0, 1'b0, 1'b1, 0, 0, -1, 0, 7'h0);  // bge not taken
    run(C_BR, 3'd0, 1'b0, 1'b1, 1'b0, 0, 0, -1, 0, 7'h0);  // beq taken
    run(C_BAD, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0, -1, 10, 7'h0); // trap, 10 cycles
    run(C_SW, 3'd2, 1'b0, 1'b0, 1'b0, 1, 2, -1, 0, 7'h0);
    run(C_SW, 3'd2, 1'b0, 1'b0, 1'b0, 0, 3, 4, 0, 7'h0);   // reset inside MEMWRITE
    run(C_JAL, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0, -1, 0, 7'h0);
    run(C_LUI, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0, -1, 0, 7'h0);
    run(C_AUIPC, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0, -1, 0, 7'h0);
    run(C_I, 3'd0, 1'b1, 1'b0, 1'b0, 0, 0, -1, 0, 7'h0);   // addi ignores F7b5
    run(C_I, 3'd1, 1'b0, 1'b0, 1'b0, 0, 0, -1, 3, 7'h0);   // bad funct3 traps
    run(C_R, 3'd7, 1'b0, 1'b0, 1'b0, 0, 0, -1, 0, 7'h0);   // and
    for (int n = 0; n < 150; n++) rand_instr();
    end_phase();

    // MEM_WAIT=0 (MemReady tied low), beq only, trapping.
    begin_phase(2'd1, 1'b0, 1'b0, 1'b1);
    run(C_LW, 3'd2, 1'b0, 1'b0, 1'b0, 2, 2, -1, 0, 7'h0);  // 5 cycles regardless
    run(C_BR, 3'd1, 1'b0, 1'b0, 1'b0, 0, 0, -1, 3, 7'h0);  // bne traps
    run(C_BR, 3'd0, 1'b0, 1'b1, 1'b0, 0, 0, -1, 0, 7'h0);  // beq taken
    run(C_SW, 3'd2, 1'b0, 1'b0, 1'b0, 0, 2, -1, 0, 7'h0);
    for (int n = 0; n < 60; n++) rand_instr();
    end_phase();

    // ILLEGAL_TRAP=0: bad encodings fall back to FETCH.
    begin_phase(2'd2, 1'b1, 1'b1, 1'b0);
    run(C_BAD, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0, -1, 0, 7'h0);
    run(C_R, 3'd5, 1'b0, 1'b0, 1'b0, 0, 0, -1, 0, 7'h0);
    run(C_R, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0, -1, 0, 7'h0);
    for (int n = 0; n < 60; n++) rand_instr();
    end_phase();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
